// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial transmitter.
package serial_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/tx_bit_counter.sv
// Loadable down-counter with zero flag; tracks remaining data bits of a frame.
module tx_bit_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, N data bits LSB-first, optional even
// parity, stop bit. Bit timing paced by bit_en.
// Define SERIAL_TX_PARITY_EN to insert the even-parity bit before the stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [N-1:0] data,
  input  logic         valid,
  output logic         ready,
  input  logic         bit_en,
  output logic         sout,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  tx_state_t    state_d, state_q;
  logic [N-1:0] shreg_d, shreg_q;
  logic         sout_d, sout_q;
  logic         done_d, done_q;
  logic         cnt_load, cnt_dec, cnt_zero;

`ifdef SERIAL_TX_PARITY_EN
  // Copy of the accepted word; parity must not see the shifting register.
  logic [N-1:0] word_d, word_q;
`endif

  tx_bit_counter #(
    .Width(CntW)
  ) u_bit_counter (
    .clk       (clk),
    .n_reset   (n_reset),
    .load_i    (cnt_load),
    .load_val_i(CntW'(N - 1)),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  // Next-state, next line level and done pulse.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    sout_d   = sout_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    word_d   = word_q;
`endif
    unique case (state_q)
      StIdle: begin
        sout_d = LINE_IDLE;
        // Accept ignores bit_en; the start bit lasts until the next strobe.
        if (valid) begin
          shreg_d = data;
`ifdef SERIAL_TX_PARITY_EN
          word_d  = data;
`endif
          sout_d  = START_BIT;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_en) begin
          sout_d   = shreg_q[0];
          cnt_load = 1'b1;
          state_d  = StData;
        end
      end
      StData: begin
        if (bit_en) begin
          if (!cnt_zero) begin
            shreg_d = shreg_q >> 1;
            sout_d  = shreg_q[1];
            cnt_dec = 1'b1;
          end else begin
`ifdef SERIAL_TX_PARITY_EN
            sout_d  = ^word_q;
            state_d = StParity;
`else
            sout_d  = STOP_BIT;
            state_d = StStop;
`endif
          end
        end
      end
      StParity: begin
        if (bit_en) begin
          sout_d  = STOP_BIT;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_en) begin
          sout_d  = LINE_IDLE;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        sout_d  = LINE_IDLE;
        state_d = StIdle;
      end
    endcase
  end

  // State, shift register and registered outputs; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      sout_q  <= LINE_IDLE;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      word_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      word_q  <= word_d;
`endif
    end
  end

  assign ready = (state_q == StIdle);
  assign busy  = (state_q != StIdle);
  assign sout  = sout_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: directed scenarios plus random traffic,
// compared every cycle against a frame-list reference model.
module tb_serial_tx;

  localparam int unsigned N = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FrameLen = N + 3;
  localparam logic [15:0] Seq1011 = 16'h0037;  // 0,1,1,0,1,1,1
`else
  localparam int FrameLen = N + 2;
  localparam logic [15:0] Seq1011 = 16'h001B;  // 0,1,1,0,1,1
`endif

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic [N-1:0] data = '0;
  logic         valid = 1'b0;
  logic         ready;
  logic         bit_en = 1'b0;
  logic         sout;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  // Reference model: a frame is a list of line levels, one per bit period.
  bit m_busy = 1'b0;
  bit exp_sout = 1'b1;
  bit exp_done = 1'b0;
  bit frame_q[$];
  int idx = 0;

  always #5 clk = ~clk;

  serial_tx #(
    .N(N)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .data   (data),
    .valid  (valid),
    .ready  (ready),
    .bit_en (bit_en),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [N-1:0] d);
    logic [15:0] r;
    r = '0;
    r = {r[14:0], 1'b0};
    for (int i = 0; i < int'(N); i++) r = {r[14:0], d[i]};
`ifdef SERIAL_TX_PARITY_EN
    r = {r[14:0], ^d};
`endif
    r = {r[14:0], 1'b1};
    return r;
  endfunction

  task automatic model_edge(input logic rst, input logic v, input logic [N-1:0] d,
                            input logic be);
    exp_done = 1'b0;
    if (!rst) begin
      m_busy   = 1'b0;
      exp_sout = 1'b1;
    end else if (!m_busy) begin
      exp_sout = 1'b1;
      if (v) begin
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 0; i < int'(N); i++) frame_q.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
        frame_q.push_back(^d);
`endif
        frame_q.push_back(1'b1);
        idx      = 0;
        m_busy   = 1'b1;
        exp_sout = frame_q[0];
      end
    end else if (be) begin
      idx++;
      if (idx == frame_q.size()) begin
        m_busy   = 1'b0;
        exp_done = 1'b1;
        exp_sout = 1'b1;
      end else begin
        exp_sout = frame_q[idx];
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, check just after it.
  task automatic step(input logic rst, input logic v, input logic [N-1:0] d, input logic be);
    n_reset = rst;
    valid   = v;
    data    = d;
    bit_en  = be;
    @(posedge clk);
    model_edge(rst, v, d, be);
    #1;
    check_eq("sout", 32'(sout), 32'(exp_sout));
    check_eq("ready", 32'(ready), 32'(!m_busy));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(exp_done));
  endtask

  // Send one word, strobing bit_en every `period` cycles; optionally toggle
  // data/valid while busy. Returns the line level seen each bit period.
  task automatic run_frame(input logic [N-1:0] d, input logic [N-1:0] mid_d,
                           input bit mid_valid, input int period,
                           output logic [15:0] seq, output int periods, output int dones);
    bit finished;
    bit be;
    bit v;
    seq      = '0;
    periods  = 0;
    dones    = 0;
    finished = 1'b0;
    step(1'b1, 1'b1, d, 1'b0);
    seq = {seq[14:0], sout};
    for (int cyc = 1; cyc < 400; cyc++) begin
      be = (cyc % period) == 0;
      v  = mid_valid && m_busy && (cyc % 2 == 1);
      step(1'b1, v, mid_d, be);
      if (mid_valid && v) check_eq("ready_while_busy", 32'(ready), 32'd0);
      if (be) begin
        periods++;
        if (busy) seq = {seq[14:0], sout};
      end
      if (done) begin
        dones++;
        finished = 1'b1;
        break;
      end
    end
    check_eq("frame_timeout", 32'(finished), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      if (done) dones++;
    end
  endtask

  initial begin
    logic [15:0] seq;
    int          periods;
    int          dones;
    logic        held;
    bit          fin;

    // Reset
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);

    // 1011, bit_en every 4th cycle
    run_frame(4'b1011, 4'b0000, 1'b0, 4, seq, periods, dones);
    check_eq("seq_1011", 32'(seq), 32'(Seq1011));
    check_eq("seq_1011_rule", 32'(seq), 32'(frame_bits(4'b1011)));
    check_eq("periods_1011", 32'(periods), 32'(FrameLen));
    check_eq("dones_1011", 32'(dones), 32'd1);

    // Accept F, then data=0 and valid pulses while busy
    run_frame(4'hF, 4'h0, 1'b1, 3, seq, periods, dones);
    check_eq("seq_F", 32'(seq), 32'(frame_bits(4'hF)));
    check_eq("data_bits_F", 32'(seq[FrameLen-2 -: 4]), 32'hF);
    check_eq("periods_F", 32'(periods), 32'(FrameLen));
    check_eq("dones_F", 32'(dones), 32'd1);

    // Mid-frame reset for 2 edges: no done afterwards
    step(1'b1, 1'b1, 4'h6, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      if (done) dones++;
    end
    check_eq("dones_after_reset", 32'(dones), 32'd0);

    // Back-to-back: A then 5 with valid held high
    step(1'b1, 1'b1, 4'hA, 1'b0);
    dones = 0;
    fin   = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      step(1'b1, 1'b1, 4'h5, (cyc % 3) == 0);
      if (done) begin
        dones++;
        // The done cycle is also the accepting cycle for the next word.
        if (dones == 1) begin
          step(1'b1, 1'b1, 4'h5, 1'b0);
          check_eq("b2b_second_start", 32'(sout), 32'd0);
        end
        if (dones == 2) begin
          fin = 1'b1;
          break;
        end
      end
    end
    check_eq("b2b_timeout", 32'(fin), 32'd1);
    check_eq("b2b_dones", 32'(dones), 32'd2);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, '0, 1'b0);

    // bit_en held low for 50 cycles inside DATA
    step(1'b1, 1'b1, 4'h9, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    held = sout;
    for (int k = 0; k < 50; k++) step(1'b1, 1'b0, '0, 1'b0);
    check_eq("stall_hold", 32'(sout), 32'(held));
    check_eq("stall_busy", 32'(busy), 32'd1);
    fin = 1'b0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      step(1'b1, 1'b0, '0, (cyc % 2) == 0);
      if (done) begin
        fin = 1'b1;
        break;
      end
    end
    check_eq("stall_resume", 32'(fin), 32'd1);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(199, 0) != 0), ($urandom_range(1, 0) == 1),
           N'($urandom_range(15, 0)), ($urandom_range(2, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
